// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined control unit.
//   - opcode class constants used by the decoder
//   - bit positions of each field inside the ID/EX control word
//   - narrower per-stage words for EX/MEM and MEM/WB plus the helpers
//     that project a wider word onto the next stage
package ctrl_pkg;

  // Opcode classes (bit 5 = MSB). Prefixes are matched on the top bits.
  localparam logic [2:0] OP_LOAD_PFX   = 3'b100;    // 100xxx
  localparam logic [2:0] OP_STORE_PFX  = 3'b101;    // 101xxx
  localparam logic [2:0] OP_ITYPE_PFX  = 3'b001;    // 001xxx
  localparam logic [4:0] OP_BRANCH_PFX = 5'b00010;  // 00010x
  localparam logic [5:0] OP_RTYPE      = 6'b000000;
  localparam logic [5:0] OP_JUMP       = 6'b000010;

  localparam int CORE_ALUOP_W = 6;

  // Control-word field indices.
  localparam int CW_REGDST   = 0;
  localparam int CW_ALUSRC   = 1;
  localparam int CW_ALUOP_LO = 2;   // AluOp occupies [7:2]
  localparam int CW_MEMREAD  = 8;
  localparam int CW_MEMWRITE = 9;
  localparam int CW_MEMTOREG = 10;
  localparam int CW_REGWRITE = 11;
  localparam int CW_BRANCH   = 12;
  localparam int CW_JUMP     = 13;
  localparam int CW_ILLEGAL  = 14;
  localparam int CW_W        = 15;

  typedef logic [CW_W-1:0] cw_t;

  localparam cw_t CW_BUBBLE = '0;

  typedef struct packed {
    logic branch;
    logic jump;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
  } mem_cw_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_cw_t;

  // EX-only fields (RegDst, ALUSrc, AluOp, illegal) are dropped here, so
  // the illegal flag never travels past EX.
  function automatic mem_cw_t to_mem(input cw_t cw);
    mem_cw_t m;
    m.branch   = cw[CW_BRANCH];
    m.jump     = cw[CW_JUMP];
    m.memread  = cw[CW_MEMREAD];
    m.memwrite = cw[CW_MEMWRITE];
    m.regwrite = cw[CW_REGWRITE];
    m.memtoreg = cw[CW_MEMTOREG];
    return m;
  endfunction

  function automatic wb_cw_t to_wb(input mem_cw_t m);
    wb_cw_t w;
    w.regwrite = m.regwrite;
    w.memtoreg = m.memtoreg;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ctrl_pipe_unit_if: handshake/control bundle of the pipelined control unit.
//   master: drives ena, flush, opcode, id_rs, id_rt; sees all outputs
//   slave : the control unit itself
interface ctrl_pipe_unit_if #(
  parameter int ALUOP_W = 6,
  parameter int REG_AW  = 5
);
  logic               ena;
  logic               flush;
  logic [5:0]         opcode;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic               load_use_stall;
  logic               ex_RegDst;
  logic               ex_ALUSrc;
  logic [ALUOP_W-1:0] ex_AluOp;
  logic               ex_illegal;
  logic               mem_Branch;
  logic               mem_Jump;
  logic               mem_MemRead;
  logic               mem_MemWrite;
  logic               wb_RegWrite;
  logic               wb_MemtoReg;

  modport master (
    output ena, flush, opcode, id_rs, id_rt,
    input  load_use_stall, ex_RegDst, ex_ALUSrc, ex_AluOp, ex_illegal,
           mem_Branch, mem_Jump, mem_MemRead, mem_MemWrite,
           wb_RegWrite, wb_MemtoReg
  );

  modport slave (
    input  ena, flush, opcode, id_rs, id_rt,
    output load_use_stall, ex_RegDst, ex_ALUSrc, ex_AluOp, ex_illegal,
           mem_Branch, mem_Jump, mem_MemRead, mem_MemWrite,
           wb_RegWrite, wb_MemtoReg
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> control word.
//   opcode  : 6-bit ID-stage opcode
//   cw      : full control word (illegal bit at CW_ILLEGAL; all other
//             fields 0 when illegal)
//   uses_rt : ID op reads rt as a source (r_type, store, branch)
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output cw_t        cw,
  output logic       uses_rt
);
  logic is_ld, is_st, is_it, is_br, is_rt, is_jp;

  always_comb begin
    is_ld = (opcode[5:3] == OP_LOAD_PFX);
    is_st = (opcode[5:3] == OP_STORE_PFX);
    is_it = (opcode[5:3] == OP_ITYPE_PFX);
    is_br = (opcode[5:1] == OP_BRANCH_PFX);
    is_rt = (opcode == OP_RTYPE);
    is_jp = (opcode == OP_JUMP);

    cw = CW_BUBBLE;
    if (is_ld | is_st | is_it | is_br | is_rt | is_jp) begin
      cw[CW_REGDST]   = is_rt;
      cw[CW_ALUSRC]   = is_ld | is_st | is_it;
      cw[CW_MEMREAD]  = is_ld;
      cw[CW_MEMWRITE] = is_st;
      cw[CW_MEMTOREG] = is_ld;
      cw[CW_REGWRITE] = is_ld | is_rt | is_it;
      cw[CW_BRANCH]   = is_br;
      cw[CW_JUMP]     = is_jp;
      cw[CW_ALUOP_LO +: CORE_ALUOP_W] = {opcode[3] & ~opcode[5], opcode[2:0],
                                         is_rt | is_it, is_br | is_it};
    end else begin
      cw[CW_ILLEGAL] = 1'b1;
    end

    uses_rt = is_rt | is_st | is_br;
  end
endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decodes the ID opcode and carries the control word
// through ID/EX, EX/MEM and MEM/WB, with load-use bubble insertion,
// branch/jump flush and illegal-opcode flagging.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : ctrl_pipe_unit_if.slave (ena/flush/opcode/id_rs/id_rt in;
//              load_use_stall, ex_*, mem_*, wb_* out)
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W   = 6,
  parameter int REG_AW    = 5,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  ctrl_pipe_unit_if.slave bus
);
  cw_t     dec_cw;
  logic    dec_uses_rt;
  cw_t     idex;
  mem_cw_t exmem;
  wb_cw_t  memwb;
  logic    stall;

  ctrl_decode u_dec (
    .opcode  (bus.opcode),
    .cw      (dec_cw),
    .uses_rt (dec_uses_rt)
  );

  generate
    if (HAZARD_EN) begin : g_haz
      logic [REG_AW-1:0] ex_rt;

      // Load in EX whose destination (rt) is a source of the ID op.
      // Not qualified by flush: upstream gives flush priority.
      assign stall = bus.ena & idex[CW_MEMREAD] &
                     ((ex_rt == bus.id_rs) | (dec_uses_rt & (ex_rt == bus.id_rt)));

      // ex_rt only matters while a load sits in EX, so it follows the
      // decoded op and simply holds across bubbles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   ex_rt <= '0;
        else if (bus.ena && !bus.flush && !stall)  ex_rt <= bus.id_rt;
      end
    end else begin : g_nohaz
      logic unused_haz;
      assign unused_haz = ^{dec_uses_rt, bus.id_rs, bus.id_rt};
      assign stall = 1'b0;
    end
  endgenerate

  assign bus.load_use_stall = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= CW_BUBBLE;
      exmem <= '0;
      memwb <= '0;
    end else if (bus.ena) begin
      // MEM/WB always advances: a flushing branch still completes.
      memwb <= to_wb(exmem);
      if (bus.flush) begin
        idex  <= CW_BUBBLE;
        exmem <= '0;
      end else begin
        exmem <= to_mem(idex);
        idex  <= stall ? CW_BUBBLE : dec_cw;
      end
    end
  end

  assign bus.ex_RegDst  = idex[CW_REGDST];
  assign bus.ex_ALUSrc  = idex[CW_ALUSRC];
  assign bus.ex_illegal = idex[CW_ILLEGAL];

  always_comb begin
    bus.ex_AluOp = '0;
    bus.ex_AluOp[CORE_ALUOP_W-1:0] = idex[CW_ALUOP_LO +: CORE_ALUOP_W];
  end

  assign bus.mem_Branch   = exmem.branch;
  assign bus.mem_Jump     = exmem.jump;
  assign bus.mem_MemRead  = exmem.memread;
  assign bus.mem_MemWrite = exmem.memwrite;
  assign bus.wb_RegWrite  = memwb.regwrite;
  assign bus.wb_MemtoReg  = memwb.memtoreg;
endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Parametrised successor to the single-register control unit. Decodes the 6-bit opcode in ID and carries the control word through the ID/EX, EX/MEM and MEM/WB pipeline registers, so each stage reads its own control bits. Adds three behaviours the previous block lacked:
- load-use hazard detection with bubble insertion
- branch/jump flush of the wrong-path stages
- illegal-opcode flagging

Sits between the instruction register and the datapath stage muxes.

Parameters:
ALUOP_W, 6, AluOp width; must be >= 6; bits above 5 are driven 0.
REG_AW, 5, register-address width used for hazard compares.
HAZARD_EN, 1, 1 = load-use detection active; 0 = load_use_stall tied 0.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ena  in  1  pipeline advance; 0 holds every stage register
flush  in  1  taken branch/jump resolved in MEM; kills ID and EX
opcode  in  6  ID-stage opcode
id_rs  in  REG_AW  ID-stage rs field
id_rt  in  REG_AW  ID-stage rt field
load_use_stall  out  1  combinational; upstream holds PC/IF-ID when 1
ex_RegDst  out  1  EX control
ex_ALUSrc  out  1  EX control
ex_AluOp  out  ALUOP_W  EX control
ex_illegal  out  1  EX-stage instruction had an undecodable opcode
mem_Branch  out  1  MEM control
mem_Jump  out  1  MEM control
mem_MemRead  out  1  MEM control
mem_MemWrite  out  1  MEM control
wb_RegWrite  out  1  WB control
wb_MemtoReg  out  1  WB control

Behaviour:
- Opcode classes (bit 5 = MSB):
  - load 100xxx, store 101xxx, i_type 001xxx
  - branch 00010x, r_type 000000, jump 000010
  - anything else is illegal
- Control word per class:
  - RegDst = r_type; ALUSrc = load|store|i_type
  - MemRead = load; MemWrite = store; MemtoReg = load
  - RegWrite = load|r_type|i_type; Branch = branch; Jump = jump
- AluOp:
  - [0] = branch|i_type
  - [1] = r_type|i_type
  - [4:2] = opcode[2:0]
  - [5] = opcode[3] & ~opcode[5]
- Illegal opcode: all controls 0, AluOp 0, illegal bit 1.
- Bubble = all-zero word, illegal = 0.
- Latency, for an opcode presented before edge n:
  - ex_* valid after edge n
  - mem_* valid after edge n+1
  - wb_* valid after edge n+2
- Hazard: load_use_stall = HAZARD_EN & ena & ex_MemRead & (ex_rt == id_rs, or ex_rt == id_rt when the ID op is r_type, store or branch).
  - ex_rt is id_rt captured into ID/EX.
  - Not qualified by flush; upstream gives flush priority.
- Register update priority, evaluated at each rising clk:
  1. rst: asynchronous; all stage registers and ex_rt clear to 0, so every output is 0 while rst is high and after release.
  2. ena = 0: all stage registers hold; load_use_stall forced 0.
  3. flush = 1: ID/EX <- bubble; EX/MEM <- bubble; MEM/WB <- EX/MEM, so the branch itself completes.
  4. load_use_stall = 1: ID/EX <- bubble; EX/MEM <- ID/EX; MEM/WB <- EX/MEM. Upstream holds, so the same opcode is re-decoded next cycle, and the stall clears because the load has moved to MEM.
  5. Otherwise: ID/EX <- decode(opcode); EX/MEM <- ID/EX; MEM/WB <- EX/MEM.
- flush and stall together: flush wins.
- Reset asserted mid-operation: in-flight control words are discarded with no partial state. The first edge after release loads the opcode normally.
- ex_illegal is a level for one EX cycle, not latched; it travels no further than EX.

Decomposition:
- ctrl_pkg holds:
  - opcode class constants (OP_LOAD_PFX, OP_STORE_PFX, OP_ITYPE_PFX, OP_BRANCH_PFX, OP_RTYPE, OP_JUMP)
  - control-word field indices
  - bubble constant
- Sub-module ctrl_decode: purely combinational, opcode -> control word plus illegal bit, reusable by the verification model.
- ctrl_pipe_unit instantiates ctrl_decode once and owns the three stage registers plus the hazard compare.

Test Plan:
1. Reset, then opcode 000000, ena=1 -> after 1 edge ex_RegDst=1, ex_AluOp=000010; after 3 edges wb_RegWrite=1, wb_MemtoReg=0.
2. lw 100011 (id_rt=5), then add 000000 with id_rs=5 -> load_use_stall=1 for exactly 1 cycle; next edge EX holds a bubble while mem_MemRead=1; add reaches EX one cycle later. Repeat with HAZARD_EN=0 -> no stall.
3. beq 000100 -> ex_AluOp=010001, mem_Branch=1. Assert flush in that MEM cycle -> following edge ex_* and mem_* all 0; wb path still carries beq (wb_RegWrite=0).
4. addi 001000 -> ex_ALUSrc=1, ex_AluOp=100011; with ALUOP_W=8, bits [7:6]=0.
5. Opcode 111111 -> ex_illegal=1 for one cycle; every other control 0 in all stages.
6. ena=0 for 3 cycles mid-stream -> all outputs frozen and load_use_stall=0. Assert rst asynchronously between edges -> all outputs 0 immediately.
